bayer_frame_server: RTL and testbench
=====================================

BAYER_FRAME_SERVER -- requirements
Module: bayer_frame_server

Interface
- REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the pixel width.
- REQ-002 The block SHALL have parameter ADDRESS, default 14, the address width (128x128 frame, 16384 words).
- REQ-003 clk  input  1  clock; all logic on rising edge.
- REQ-004 rst  input  1  reset, asynchronous, active-high.
- REQ-005 start  input  1  single-cycle pulse that begins a frame.
- REQ-006 Load port inputs SHALL be: load_valid 1, load_data DATA_WIDTH (raster-order image words).
- REQ-007 load_ready  output  1  high while load beats are accepted.
- REQ-008 Bayer read port inputs SHALL be: bayer_addr ADDRESS, bayer_req 1.
- REQ-009 bayer_ready  output  1  frame available for reads.
- REQ-010 bayer_data  output  DATA_WIDTH  read data.
- REQ-011 Result write port inputs SHALL be: acpi_addr ADDRESS, acpi_valid 1, acpi_data DATA_WIDTH.
- REQ-012 finish  input  1  demosaic-complete indication.
- REQ-013 Dump port outputs SHALL be: dump_valid 1, dump_data DATA_WIDTH.
- REQ-014 dump_ready  input  1  consumer accepts the dump beat.
- REQ-015 done  output  1  frame cycle complete.

Function
- REQ-016 FSM states SHALL be IDLE, LOAD, SERVE, DUMP, DONE.
- REQ-017 Transitions SHALL be: IDLE->LOAD on start; LOAD->SERVE after beat 16383 accepted; SERVE->DUMP on finish; DUMP->DONE after dump beat 16383 accepted; DONE->LOAD on start.
- REQ-018 start SHALL be ignored in LOAD, SERVE and DUMP.
- REQ-019 In LOAD, load_ready SHALL be 1; each cycle with load_valid&load_ready SHALL write load_data to the image memory at load counter, then increment the counter; the counter SHALL clear on entry to LOAD.
- REQ-020 In SERVE, bayer_ready SHALL be 1; a cycle with bayer_req=1 SHALL present image[bayer_addr] on bayer_data at the next edge (latency 1); with bayer_req=0, bayer_data SHALL hold.
- REQ-021 In SERVE, acpi_valid=1 SHALL write acpi_data to the result memory at acpi_addr; a repeated address SHALL be last-write-wins.
- REQ-022 acpi_valid, bayer_req and load_valid outside their states SHALL have no effect.
- REQ-023 finish and acpi_valid in the same SERVE cycle SHALL commit the write and then enter DUMP.
- REQ-024 In DUMP, result words SHALL stream in address order 0..16383; dump_data and dump_valid SHALL hold while dump_valid&!dump_ready.
- REQ-025 done SHALL be 1 only in DONE.
- REQ-026 Address arithmetic SHALL wrap modulo 2^ADDRESS.

Reset
- REQ-027 Asserting rst SHALL force IDLE, counters 0 and all outputs 0 (load_ready, bayer_ready, bayer_data, dump_valid, dump_data, done); this applies mid-frame.
- REQ-028 rst SHALL NOT clear memory contents.

Configuration
- REQ-029 With ACPI_WR_COUNT_EN defined, the block SHALL add output acpi_wr_count (ADDRESS+1 bits), counting accepted SERVE writes, saturating at 2^(ADDRESS+1)-1, cleared on entry to SERVE and on rst.
- REQ-030 Without ACPI_WR_COUNT_EN, the port and counter SHALL be absent.

Structure
- REQ-031 The shared package SHALL hold the state enum, FRAME_WORDS=16384, and DATA_WIDTH/ADDRESS defaults.
- REQ-032 The two frame memories SHALL each be an instance of one sub-module frame_ram (1 write port, 1 registered read port).

Verification
- REQ-033 Load ramp data=addr[7:0]; bayer_req at addr 258 -> bayer_data=0x02 one cycle later; bayer_req=0 -> held.
- REQ-034 Writes at 259=0xAA and 261=0x55, finish, dump_ready=1 -> dump words 259=0xAA and 261=0x55; dump ends; done=1.
- REQ-035 dump_ready toggled 1/0 each cycle -> no word dropped or duplicated; 16384 beats.
- REQ-036 finish with acpi_valid (addr 16382, 0x77) -> dumped word 16382=0x77.
- REQ-037 rst asserted mid-LOAD at beat 5000 -> IDLE, outputs 0; start then full reload -> bayer_ready=1.
- REQ-038 With ACPI_WR_COUNT_EN, 3 writes including one repeated address -> acpi_wr_count=3.

Source files
------------

// File: rtl/bayer_frame_server_pkg.sv
// Shared types and defaults for the Bayer frame server: FSM state encoding,
// frame size and the default pixel/address widths.
package bayer_frame_server_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDRESS_DEF    = 14;
    localparam int FRAME_WORDS    = 16384;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SERVE = 3'd2,
        DUMP  = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/bayer_frame_server_if.sv
// Bus bundle for the Bayer frame server; master = frame producer/consumer side,
// slave = the server. acpi_wr_count exists only when ACPI_WR_COUNT_EN is defined.
interface bayer_frame_server_if #(
    parameter int DATA_WIDTH = bayer_frame_server_pkg::DATA_WIDTH_DEF,
    parameter int ADDRESS    = bayer_frame_server_pkg::ADDRESS_DEF
);
    // Handshakes: a load beat transfers on a rising edge with load_valid & load_ready,
    // a dump beat with dump_valid & dump_ready; a stalled dump beat keeps valid and data stable.
    logic                  start;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_ready;
    logic [ADDRESS-1:0]    bayer_addr;
    logic                  bayer_req;
    logic                  bayer_ready;
    logic [DATA_WIDTH-1:0] bayer_data;
    logic [ADDRESS-1:0]    acpi_addr;
    logic                  acpi_valid;
    logic [DATA_WIDTH-1:0] acpi_data;
    logic                  finish;
    logic                  dump_valid;
    logic [DATA_WIDTH-1:0] dump_data;
    logic                  dump_ready;
    logic                  done;
`ifdef ACPI_WR_COUNT_EN
    logic [ADDRESS:0]      acpi_wr_count;
`endif

    modport master (
        output start, load_valid, load_data, bayer_addr, bayer_req,
               acpi_addr, acpi_valid, acpi_data, finish, dump_ready,
        input  load_ready, bayer_ready, bayer_data, dump_valid, dump_data, done
`ifdef ACPI_WR_COUNT_EN
        , input acpi_wr_count
`endif
    );

    modport slave (
        input  start, load_valid, load_data, bayer_addr, bayer_req,
               acpi_addr, acpi_valid, acpi_data, finish, dump_ready,
        output load_ready, bayer_ready, bayer_data, dump_valid, dump_data, done
`ifdef ACPI_WR_COUNT_EN
        , output acpi_wr_count
`endif
    );

endinterface

// File: rtl/bayer_frame_server_frame_ram.sv
// Single-port-write frame memory with one registered read port. Only the read
// register is reset; the array keeps its contents across rst.
module frame_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDRESS    = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDRESS-1:0]    waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDRESS-1:0]    raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    localparam int DEPTH = 1 << ADDRESS;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read data holds whenever no read is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bayer_frame_server.sv
// Frame server: loads a raster image, serves random reads while collecting
// demosaic results, then streams the result frame. Optional ACPI_WR_COUNT_EN.
module bayer_frame_server
    import bayer_frame_server_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDRESS    = ADDRESS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    bayer_frame_server_if.slave bus,
    output state_e              state_o
);
    localparam logic [ADDRESS-1:0] LAST_ADDR = ADDRESS'(FRAME_WORDS - 1);
    localparam logic [ADDRESS-1:0] ADDR_ONE  = ADDRESS'(1);

    state_e                state_q;
    logic [ADDRESS-1:0]    load_cnt_q, load_cnt_d;
    logic [ADDRESS-1:0]    dump_cnt_q, dump_cnt_d;
    logic                  load_ready_q, bayer_ready_q, dump_valid_q, done_q;
    logic                  img_we, img_re, res_we, res_re, dump_fire, load_last;
    logic [ADDRESS-1:0]    res_raddr;
    logic [DATA_WIDTH-1:0] bayer_rdata, dump_rdata;

    assign load_cnt_d = load_cnt_q + ADDR_ONE;
    assign dump_cnt_d = dump_cnt_q + ADDR_ONE;
    assign img_we     = (state_q == LOAD) && bus.load_valid;
    assign load_last  = img_we && (load_cnt_q == LAST_ADDR);
    assign img_re     = (state_q == SERVE) && bus.bayer_req;
    assign res_we     = (state_q == SERVE) && bus.acpi_valid;
    assign dump_fire  = dump_valid_q && bus.dump_ready;

    // First DUMP cycle fetches word 0; afterwards each accepted beat prefetches the next.
    assign res_re    = (state_q == DUMP) &&
                       (!dump_valid_q || (dump_fire && (dump_cnt_q != LAST_ADDR)));
    assign res_raddr = dump_valid_q ? dump_cnt_d : dump_cnt_q;

    frame_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS(ADDRESS)) u_image_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (img_we),
        .waddr_i (load_cnt_q),
        .wdata_i (bus.load_data),
        .re_i    (img_re),
        .raddr_i (bus.bayer_addr),
        .rdata_o (bayer_rdata)
    );

    frame_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS(ADDRESS)) u_result_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (res_we),
        .waddr_i (bus.acpi_addr),
        .wdata_i (bus.acpi_data),
        .re_i    (res_re),
        .raddr_i (res_raddr),
        .rdata_o (dump_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            load_cnt_q    <= '0;
            dump_cnt_q    <= '0;
            load_ready_q  <= 1'b0;
            bayer_ready_q <= 1'b0;
            dump_valid_q  <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q      <= LOAD;
                        load_cnt_q   <= '0;
                        load_ready_q <= 1'b1;
                        done_q       <= 1'b0;
                    end
                end
                LOAD: begin
                    if (img_we) begin
                        load_cnt_q <= load_cnt_d;
                    end
                    if (load_last) begin
                        state_q       <= SERVE;
                        load_ready_q  <= 1'b0;
                        bayer_ready_q <= 1'b1;
                    end
                end
                SERVE: begin
                    if (bus.finish) begin
                        state_q       <= DUMP;
                        bayer_ready_q <= 1'b0;
                        dump_cnt_q    <= '0;
                        dump_valid_q  <= 1'b0;
                    end
                end
                DUMP: begin
                    if (!dump_valid_q) begin
                        dump_valid_q <= 1'b1;
                    end else if (bus.dump_ready) begin
                        if (dump_cnt_q == LAST_ADDR) begin
                            state_q      <= DONE;
                            dump_valid_q <= 1'b0;
                            done_q       <= 1'b1;
                        end else begin
                            dump_cnt_q <= dump_cnt_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ACPI_WR_COUNT_EN
    logic [ADDRESS:0] wr_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count_q <= '0;
        end else if (load_last) begin
            wr_count_q <= '0;
        end else if (res_we && (wr_count_q != '1)) begin
            wr_count_q <= wr_count_q + 1'b1;
        end
    end

    assign bus.acpi_wr_count = wr_count_q;
`endif

    assign bus.load_ready  = load_ready_q;
    assign bus.bayer_ready = bayer_ready_q;
    assign bus.bayer_data  = bayer_rdata;
    assign bus.dump_valid  = dump_valid_q;
    assign bus.dump_data   = dump_rdata;
    assign bus.done        = done_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_bayer_frame_server.sv
// Bench for bayer_frame_server: frame-level model of the load/serve/dump cycle
// checked every cycle, plus literal expectations at key points.
module tb_bayer_frame_server;
    localparam int DW    = 8;
    localparam int AW    = 14;
    localparam int WORDS = 16384;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bayer_frame_server_if #(.DATA_WIDTH(DW), .ADDRESS(AW)) bus ();
    bayer_frame_server_pkg::state_e dbg_state;

    bayer_frame_server #(.DATA_WIDTH(DW), .ADDRESS(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (dbg_state)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // ---------------- frame-level model ----------------
    typedef enum {M_IDLE, M_LOAD, M_SERVE, M_DUMP, M_DONE} m_phase_t;
    m_phase_t        m_phase = M_IDLE;
    int              m_load_cnt;
    int              m_dump_idx;
    int              dump_beats = 0;
    logic [DW-1:0]   m_img [WORDS];
    logic [DW-1:0]   m_res [WORDS];
    bit              m_wr  [WORDS];
    logic [DW-1:0]   dump_cap [WORDS];
    logic [DW-1:0]   m_bayer_exp = '0;
    bit              checking = 0;
    bit              prev_hold = 0;
    logic [DW-1:0]   prev_data = '0;

    // Outputs settle after each rising edge; inputs for the next edge are stable here too.
    always @(negedge clk) begin
        if (checking) begin
            if (rst) begin
                m_phase     = M_IDLE;
                m_bayer_exp = '0;
                prev_hold   = 0;
            end
            check("load_ready", bus.load_ready, m_phase == M_LOAD);
            check("bayer_ready", bus.bayer_ready, m_phase == M_SERVE);
            check("done", bus.done, m_phase == M_DONE);
            check("bayer_data", bus.bayer_data, m_bayer_exp);
            if (m_phase != M_DUMP) check("dump_valid_outside_dump", bus.dump_valid, 0);
            if (rst) check("dump_data_reset", bus.dump_data, 0);
            if (prev_hold && !rst) begin
                check("dump_hold_valid", bus.dump_valid, 1);
                check("dump_hold_data", bus.dump_data, prev_data);
            end
            prev_hold = bus.dump_valid && !bus.dump_ready;
            prev_data = bus.dump_data;
            if (!rst) begin
                case (m_phase)
                    M_IDLE, M_DONE: begin
                        if (bus.start) begin
                            m_phase    = M_LOAD;
                            m_load_cnt = 0;
                        end
                    end
                    M_LOAD: begin
                        if (bus.load_valid) begin
                            m_img[m_load_cnt] = bus.load_data;
                            m_load_cnt++;
                            if (m_load_cnt == WORDS) m_phase = M_SERVE;
                        end
                    end
                    M_SERVE: begin
                        if (bus.bayer_req) m_bayer_exp = m_img[bus.bayer_addr];
                        if (bus.acpi_valid) begin
                            m_res[bus.acpi_addr] = bus.acpi_data;
                            m_wr[bus.acpi_addr]  = 1;
                        end
                        if (bus.finish) begin
                            m_phase    = M_DUMP;
                            m_dump_idx = 0;
                        end
                    end
                    M_DUMP: begin
                        if (bus.dump_valid && bus.dump_ready) begin
                            dump_cap[m_dump_idx] = bus.dump_data;
                            if (m_wr[m_dump_idx]) check("dump_word", bus.dump_data, m_res[m_dump_idx]);
                            m_dump_idx++;
                            dump_beats++;
                            if (m_dump_idx == WORDS) m_phase = M_DONE;
                        end
                    end
                    default: m_phase = M_IDLE;
                endcase
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input int n, input bit with_noise);
        for (int b = 0; b < n; b++) begin
            if (with_noise && (b % 4096 == 100)) begin
                bus.load_valid = 1'b0;
                tick();
            end
            bus.load_valid = 1'b1;
            bus.load_data  = b[7:0];
            bus.start      = with_noise && (b == 1000);
            bus.bayer_req  = with_noise && (b == 2000);
            bus.bayer_addr = 14'd5;
            tick();
        end
        bus.load_valid = 1'b0;
        bus.start      = 1'b0;
        bus.bayer_req  = 1'b0;
    endtask

    task automatic bayer_read(input int addr);
        bus.bayer_req  = 1'b1;
        bus.bayer_addr = addr[AW-1:0];
        tick();
        bus.bayer_req  = 1'b0;
    endtask

    task automatic acpi_write(input int addr, input logic [DW-1:0] data);
        bus.acpi_valid = 1'b1;
        bus.acpi_addr  = addr[AW-1:0];
        bus.acpi_data  = data;
        tick();
        bus.acpi_valid = 1'b0;
    endtask

    initial begin
        bit got_done;
        bus.start = 0; bus.load_valid = 0; bus.load_data = '0;
        bus.bayer_addr = '0; bus.bayer_req = 0;
        bus.acpi_addr = '0; bus.acpi_valid = 0; bus.acpi_data = '0;
        bus.finish = 0; bus.dump_ready = 0;

        // Reset and idle outputs
        tick();
        rst = 1'b1;
        checking = 1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_outputs", {bus.load_ready, bus.bayer_ready, bus.dump_valid, bus.done,
                                bus.bayer_data, bus.dump_data}, 0);

        // Reset in the middle of a load
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("load_ready_after_start", bus.load_ready, 1);
        load_frame(5000, 0);
        rst = 1'b1;
        #1;
        check("midload_reset_state", dbg_state, 32'(bayer_frame_server_pkg::IDLE));
        check("midload_reset_outputs", {bus.load_ready, bus.bayer_ready, bus.dump_valid, bus.done,
                                        bus.bayer_data, bus.dump_data}, 0);
        tick();
        tick();
        rst = 1'b0;

        // Full reload with ramp data, ignored start/bayer_req pulses inside
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        load_frame(WORDS, 1);
        check("bayer_ready_after_load", bus.bayer_ready, 1);
        check("load_ready_after_load", bus.load_ready, 0);

        // Serve reads
        bayer_read(258);
        check("read_258", bus.bayer_data, 8'h02);
        bus.bayer_addr = 14'd300;
        tick();
        check("read_hold", bus.bayer_data, 8'h02);
        bayer_read(16383);
        check("read_16383", bus.bayer_data, 8'hFF);
        bayer_read(12345);
        check("read_12345", bus.bayer_data, 8'h39);
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hFF;
        bus.start      = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        bus.start      = 1'b0;
        bayer_read(0);
        check("read_0_after_stray_load", bus.bayer_data, 8'h00);
        check("still_serving", bus.bayer_ready, 1);

        // Result writes, including a repeated address
        acpi_write(259, 8'h11);
        acpi_write(259, 8'hAA);
        acpi_write(261, 8'h55);
`ifdef ACPI_WR_COUNT_EN
        check("acpi_wr_count_3", bus.acpi_wr_count, 3);
`endif
        for (int i = 0; i < 32; i++) acpi_write(i * 509 + 7, 8'((i * 37 + 5) & 8'hFF));

        // Finish with a coincident write
        bus.finish     = 1'b1;
        bus.acpi_valid = 1'b1;
        bus.acpi_addr  = 14'd16382;
        bus.acpi_data  = 8'h77;
        tick();
        bus.finish     = 1'b0;
        bus.acpi_valid = 1'b0;

        // Dump with dump_ready toggling; stray writes/start must be ignored
        got_done = 0;
        for (int c = 0; c < 40000 && !got_done; c++) begin
            bus.dump_ready = (c % 2 == 0);
            bus.acpi_valid = (c < 3);
            bus.acpi_addr  = 14'd261;
            bus.acpi_data  = 8'hEE;
            bus.start      = (c == 10);
            tick();
            if (bus.done) got_done = 1;
        end
        bus.acpi_valid = 1'b0;
        bus.start      = 1'b0;
        bus.dump_ready = 1'b0;
        check("dump_completed", got_done, 1);
        check("dump_beats", dump_beats, WORDS);
        check("dump_259", dump_cap[259], 8'hAA);
        check("dump_261", dump_cap[261], 8'h55);
        check("dump_16382", dump_cap[16382], 8'h77);
        check("done_high", bus.done, 1);
`ifdef ACPI_WR_COUNT_EN
        check("acpi_wr_count_total", bus.acpi_wr_count, 36);
`endif

        // DONE -> LOAD on start
        tick();
        check("done_holds", bus.done, 1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("reload_load_ready", bus.load_ready, 1);
        check("reload_done_low", bus.done, 0);
        load_frame(10, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
